// File: rtl/tdm_demux4.sv
// Receive side of the 4-channel bit-interleaved TDM link: routes serial bits into four
// per-channel shift registers and presents a parallel frame. Define TDM_STRICT_SYNC_EN to require frame_sync on every frame.
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [4*WIDTH-1:0]   dout,
  output logic                 dout_valid,
  output logic [1:0]           slot,
  output logic                 locked,
  output logic                 sync_err
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic {HUNT, SYNC} state_t;

  state_t                    state, next_state;
  logic [BW-1:0]             bit_idx, bit_idx_next;
  logic [1:0]                slot_next;
  logic [3:0][WIDTH-1:0]     chan, chan_next;
  logic                      frame_done;
  logic                      err;
  logic                      at_start;

  assign at_start = (slot == 2'd0) && (bit_idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= next_state;
  end

  // Each channel sees exactly WIDTH shifts per frame, so stale bits left by a
  // discarded partial frame are pushed out without an explicit clear.
  always_comb begin
    next_state   = state;
    slot_next    = slot;
    bit_idx_next = bit_idx;
    chan_next    = chan;
    frame_done   = 1'b0;
    err          = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (frame_sync) begin
            chan_next[0] = {chan[0][WIDTH-2:0], din};
            slot_next    = 2'd1;
            bit_idx_next = '0;
            next_state   = SYNC;
          end
        end
        SYNC: begin
          if (frame_sync && !at_start) begin
            err          = 1'b1;
            chan_next[0] = {chan[0][WIDTH-2:0], din};
            slot_next    = 2'd1;
            bit_idx_next = '0;
          end
`ifdef TDM_STRICT_SYNC_EN
          else if (!frame_sync && at_start) begin
            err          = 1'b1;
            slot_next    = 2'd0;
            bit_idx_next = '0;
            next_state   = HUNT;
          end
`endif
          else begin
            chan_next[slot] = {chan[slot][WIDTH-2:0], din};
            slot_next       = slot + 2'd1;
            if (slot == 2'd3) begin
              if (bit_idx == LAST_BIT) begin
                bit_idx_next = '0;
                frame_done   = 1'b1;
              end else begin
                bit_idx_next = bit_idx + 1'b1;
              end
            end
          end
        end
        default: next_state = HUNT;
      endcase
    end
  end

  always_comb begin
    locked = (state == SYNC);
  end

  // dout takes chan_next so the final bit of the frame is included in the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot       <= 2'd0;
      bit_idx    <= '0;
      chan       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      slot       <= slot_next;
      bit_idx    <= bit_idx_next;
      chan       <= chan_next;
      dout_valid <= frame_done;
      sync_err   <= err;
      if (frame_done) dout <= chan_next;
    end
  end

endmodule
